// File: rtl/ddr_pll_rst_ctrl.sv
// ddr_pll_rst_ctrl: reset and lock sequencer for the DDR3 core PLL.
// Pulses the PLL reset, debounces the synchronized lock, ungates clkout0,
// then releases the DDR PHY reset. Retries on timeout or lock loss and
// latches a fault once the retry budget is used up.
//
// Ports:
//   clk          - PLL reference clock (same net as PLL clkin1)
//   rst_n        - asynchronous active-low reset
//   restart      - single-cycle pulse, restarts the sequence from any state
//   pll_lock     - PLL lock output, asynchronous to clk
//   pll_rst      - PLL reset, active high
//   clkout0_gate - 1 = clkout0 stopped, 0 = running
//   ddr_rst_n    - active-low reset for the DDR PHY/controller
//   pll_ready    - sequence complete, clocks valid
//   pll_fail     - latched fault, retries exhausted
//   retry_cnt    - failures since the last successful lock or restart
module ddr_pll_rst_ctrl #(
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT = 5000,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned GATE_SETTLE  = 16,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       clkout0_gate,
  output logic       ddr_rst_n,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [3:0] retry_cnt
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (LOCK_STABLE > GATE_SETTLE) ? LOCK_STABLE : GATE_SETTLE;
  localparam int unsigned TMAX   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  // Terminal counts. The STABLE count is offset by two: the lock_s sample
  // taken in WAIT_LOCK is the first stable cycle, and the timer starts at 0.
  localparam logic [TW-1:0] T_RST  = TW'((RST_CYCLES   >= 1) ? RST_CYCLES - 1   : 0);
  localparam logic [TW-1:0] T_TO   = TW'((LOCK_TIMEOUT >= 1) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] T_STB  = TW'((LOCK_STABLE  >= 2) ? LOCK_STABLE - 2  : 0);
  localparam logic [TW-1:0] T_GATE = TW'((GATE_SETTLE  >= 1) ? GATE_SETTLE - 1  : 0);
  localparam logic [TW-1:0] T_SAT  = TW'(TMAX);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST, S_WAIT, S_STABLE, S_GATE, S_RUN, S_FAIL
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [3:0]    retry_nxt, retry_inc;
  logic          lock_meta, lock_s;
  logic          fail_evt;

  // Next-state and retry bookkeeping; restart overrides everything.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    fail_evt  = 1'b0;
    retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
    case (state)
      S_RST:    if (timer == T_RST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (lock_s)               state_nxt = S_STABLE;
        else if (timer == T_TO)   fail_evt  = 1'b1;
      end
      S_STABLE: begin
        if (!lock_s)              fail_evt  = 1'b1;
        else if (timer == T_STB)  state_nxt = S_GATE;
      end
      S_GATE: begin
        if (!lock_s)              fail_evt  = 1'b1;
        else if (timer == T_GATE) state_nxt = S_RUN;
      end
      S_RUN:    if (!lock_s) fail_evt = 1'b1;
      S_FAIL:   state_nxt = S_FAIL;
      default:  state_nxt = S_RST;
    endcase
    if (fail_evt) begin
      retry_nxt = retry_inc;
      state_nxt = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RST;
    end
    if (state_nxt == S_RUN && state != S_RUN) retry_nxt = 4'd0;
    if (restart) begin
      state_nxt = S_RST;
      retry_nxt = 4'd0;
    end
  end

  // State, shared timer, lock synchronizer and outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RST;
      timer        <= '0;
      lock_meta    <= 1'b0;
      lock_s       <= 1'b0;
      retry_cnt    <= 4'd0;
      pll_rst      <= 1'b1;
      clkout0_gate <= 1'b1;
      ddr_rst_n    <= 1'b0;
      pll_ready    <= 1'b0;
      pll_fail     <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      if (state_nxt != state || restart) timer <= '0;
      else if (timer != T_SAT)           timer <= timer + TW'(1);
      pll_rst      <= (state_nxt == S_RST) || (state_nxt == S_FAIL);
      clkout0_gate <= !((state_nxt == S_GATE) || (state_nxt == S_RUN));
      ddr_rst_n    <= (state_nxt == S_RUN);
      pll_ready    <= (state_nxt == S_RUN);
      pll_fail     <= (state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_ddr_pll_rst_ctrl.sv
// Testbench for ddr_pll_rst_ctrl: scoreboard of expected output changes,
// each tagged with the clock edge on which it must appear.
module tb_ddr_pll_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_rst, clkout0_gate, ddr_rst_n, pll_ready, pll_fail;
  logic [3:0] retry_cnt;

  always #5 clk = ~clk;

  ddr_pll_rst_ctrl #(
    .RST_CYCLES(8), .LOCK_TIMEOUT(64), .LOCK_STABLE(16),
    .GATE_SETTLE(4), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .clkout0_gate(clkout0_gate), .ddr_rst_n(ddr_rst_n),
    .pll_ready(pll_ready), .pll_fail(pll_fail), .retry_cnt(retry_cnt)
  );

  // {pll_rst, clkout0_gate, ddr_rst_n, pll_ready, pll_fail, retry_cnt}
  logic [8:0] vec;
  assign vec = {pll_rst, clkout0_gate, ddr_rst_n, pll_ready, pll_fail, retry_cnt};

  localparam logic [8:0] V_RST = 9'b1_1_0_0_0_0000;

  typedef struct {
    int         at;
    logic [8:0] val;
    string      name;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [8:0] prev;

  always @(posedge clk) cyc <= cyc + 1;

  // Every output change must match the next scoreboard entry in edge and value.
  always @(negedge clk) begin
    if (mon_en && vec !== prev) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: edge %0d outputs %b, required unchanged %b", cyc, vec, prev);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.at !== cyc || mon_e.val !== vec) begin
          errors++;
          $display("FAIL %s: edge %0d outputs %b, required edge %0d outputs %b",
                   mon_e.name, cyc, vec, mon_e.at, mon_e.val);
        end
      end
      prev = vec;
    end
  end

  function automatic logic [8:0] v(bit r, bit g, bit d, bit rdy, bit f, int rc);
    return {r, g, d, rdy, f, 4'(rc)};
  endfunction

  task automatic expect_at(input int at, input logic [8:0] val, input string name);
    exp_t e;
    e.at = at; e.val = val; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark(output int b);
    @(posedge clk);
    #1;
    b = cyc;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (sbq.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected changes never seen, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; restart = 1'b0; pll_lock = 1'b0;
    step(3);
    checks++;
    if (vec !== V_RST) begin
      errors++;
      $display("FAIL reset_values: outputs %b, required %b", vec, V_RST);
    end
    prev   = vec;
    mon_en = 1'b1;
  endtask

  task automatic test_nominal();
    int b;
    mark(b);
    rst_n = 1'b1;
    expect_at(b + 8,  v(0,1,0,0,0,0), "nom_pll_rst_fall");
    expect_at(b + 38, v(0,0,0,0,0,0), "nom_gate_open");
    expect_at(b + 42, v(0,0,1,1,0,0), "nom_run");
    step(20);
    pll_lock = 1'b1;
    drain("nominal", 100);
    checks++;
    if (pll_ready !== 1'b1 || retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL nom_final: ready %b retry %0d, required ready 1 retry 0", pll_ready, retry_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int b;
    mark(b);
    pll_lock = 1'b0;
    expect_at(b + 3,  v(1,1,0,0,0,1), "loss_detect");
    expect_at(b + 11, v(0,1,0,0,0,1), "loss_pll_rst_fall");
    step(15);
    pll_lock = 1'b1;
    expect_at(b + 33, v(0,0,0,0,0,1), "loss_gate_open");
    expect_at(b + 37, v(0,0,1,1,0,0), "loss_run_again");
    drain("lock_loss", 100);
    checks++;
    if (retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL loss_retry_clear: retry %0d, required 0", retry_cnt);
    end
  endtask

  task automatic test_restart_vs_failure();
    int b;
    mark(b);
    pll_lock = 1'b0;
    step(2);
    restart = 1'b1;
    expect_at(b + 3, v(1,1,0,0,0,0), "rvf_restart_wins");
    step(1);
    restart = 1'b0;
    pll_lock = 1'b1;
    checks++;
    if (retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rvf_retry: retry %0d, required 0", retry_cnt);
    end
    expect_at(b + 11, v(0,1,0,0,0,0), "rvf_pll_rst_fall");
    expect_at(b + 27, v(0,0,0,0,0,0), "rvf_gate_open");
    expect_at(b + 31, v(0,0,1,1,0,0), "rvf_run");
    drain("restart_vs_failure", 100);
  endtask

  task automatic test_debounce();
    int b;
    mark(b);
    restart = 1'b1;
    expect_at(b + 1, v(1,1,0,0,0,0), "deb_restart");
    step(1);
    restart = 1'b0;
    expect_at(b + 9, v(0,1,0,0,0,0), "deb_pll_rst_fall");
    step(17);
    pll_lock = 1'b0;
    expect_at(b + 21, v(1,1,0,0,0,1), "deb_glitch_fail");
    step(3);
    pll_lock = 1'b1;
    expect_at(b + 29, v(0,1,0,0,0,1), "deb_pll_rst_fall2");
    expect_at(b + 45, v(0,0,0,0,0,1), "deb_gate_open");
    expect_at(b + 49, v(0,0,1,1,0,0), "deb_run");
    drain("debounce", 100);
  endtask

  task automatic test_timeout_fail();
    int b;
    mark(b);
    restart  = 1'b1;
    pll_lock = 1'b0;
    expect_at(b + 1,   v(1,1,0,0,0,0), "to_restart");
    expect_at(b + 9,   v(0,1,0,0,0,0), "to_wait1");
    expect_at(b + 73,  v(1,1,0,0,0,1), "to_timeout1");
    expect_at(b + 81,  v(0,1,0,0,0,1), "to_wait2");
    expect_at(b + 145, v(1,1,0,0,0,2), "to_timeout2");
    expect_at(b + 153, v(0,1,0,0,0,2), "to_wait3");
    expect_at(b + 217, v(1,1,0,0,1,3), "to_fail");
    step(1);
    restart = 1'b0;
    drain("timeout", 300);
    step(100);
    checks++;
    if (pll_rst !== 1'b1 || pll_fail !== 1'b1 || retry_cnt !== 4'd3) begin
      errors++;
      $display("FAIL to_fail_hold: pll_rst %b fail %b retry %0d, required 1 1 3", pll_rst, pll_fail, retry_cnt);
    end
  endtask

  task automatic test_recovery();
    int b;
    mark(b);
    restart  = 1'b1;
    pll_lock = 1'b1;
    expect_at(b + 1, v(1,1,0,0,0,0), "rec_restart");
    step(1);
    restart = 1'b0;
    checks++;
    if (pll_fail !== 1'b0 || retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rec_clear: fail %b retry %0d, required 0 0", pll_fail, retry_cnt);
    end
    expect_at(b + 9,  v(0,1,0,0,0,0), "rec_pll_rst_fall");
    expect_at(b + 25, v(0,0,0,0,0,0), "rec_gate_open");
    expect_at(b + 29, v(0,0,1,1,0,0), "rec_run");
    drain("recovery", 100);
  endtask

  task automatic test_async_reset();
    int b;
    int r;
    mark(b);
    restart = 1'b1;
    expect_at(b + 1,  v(1,1,0,0,0,0), "ar_restart");
    expect_at(b + 9,  v(0,1,0,0,0,0), "ar_pll_rst_fall");
    expect_at(b + 25, v(0,0,0,0,0,0), "ar_gate_open");
    step(1);
    restart = 1'b0;
    drain("async_setup", 100);
    #1;
    checks++;
    if (clkout0_gate !== 1'b0) begin
      errors++;
      $display("FAIL ar_in_gate: clkout0_gate %b, required 0", clkout0_gate);
    end
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (vec !== V_RST) begin
      errors++;
      $display("FAIL ar_immediate: outputs %b, required %b", vec, V_RST);
    end
    step(2);
    prev   = vec;
    mon_en = 1'b1;
    mark(r);
    rst_n = 1'b1;
    expect_at(r + 8,  v(0,1,0,0,0,0), "ar_restart_seq");
    expect_at(r + 24, v(0,0,0,0,0,0), "ar_gate_open2");
    expect_at(r + 28, v(0,0,1,1,0,0), "ar_run");
    drain("async_resume", 100);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_restart_vs_failure();
    test_debounce();
    test_timeout_fail();
    test_recovery();
    test_async_reset();
    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ddr_pll_rst_ctrl.md
# ddr_pll_rst_ctrl

Reset and lock sequencer for the DDR3 core PLL. It runs on the 50 MHz PLL reference clock and drives the PLL reset input. It debounces the asynchronous lock output, then releases the clkout0 gate and finally the downstream DDR PHY reset. On lock timeout or loss of lock it retries the PLL a bounded number of times, and after that it latches a fault.

## Interface
Parameters:
- `RST_CYCLES`, 8: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 5000: max cycles waiting for synchronized lock per attempt.
- `LOCK_STABLE`, 64: consecutive synchronized-lock cycles required before ungating.
- `GATE_SETTLE`, 16: cycles between ungating clkout0 and releasing `ddr_rst_n`.
- `MAX_RETRY`, 3: consecutive failed attempts before FAIL (1..15).

Ports:
- `clk`  in  1: PLL reference clock, same net as the PLL clkin1.
- `rst_n`  in  1: asynchronous active-low reset.
- `restart`  in  1: synchronous single-cycle pulse that restarts the sequence from any state.
- `pll_lock`  in  1: PLL lock output, asynchronous to `clk`.
- `pll_rst`  out  1: PLL reset, active high.
- `clkout0_gate`  out  1: PLL clkout0 gate control. 1 = clkout0 stopped, 0 = running.
- `ddr_rst_n`  out  1: active-low reset for the DDR PHY/controller.
- `pll_ready`  out  1: sequence complete, clocks valid.
- `pll_fail`  out  1: latched fault, retries exhausted.
- `retry_cnt`  out  4: failures counted since the last successful lock or restart.

## Operation
- `lock_s` is a 2-flop synchronizer of `pll_lock`; both flops reset to 0. All decisions use `lock_s` only.
- One shared timer, wide enough for the largest parameter; it clears on every state change.
- State RST:
  - `pll_rst`=1, `clkout0_gate`=1, `ddr_rst_n`=0, `pll_ready`=0.
  - After `RST_CYCLES` cycles → WAIT_LOCK.
- State WAIT_LOCK:
  - `pll_rst`=0.
  - `lock_s`=1 → STABLE.
  - Timer reaches `LOCK_TIMEOUT` with `lock_s`=0 → failure.
- State STABLE:
  - `lock_s`=0 at any cycle → failure.
  - `LOCK_STABLE` consecutive cycles of `lock_s`=1 → GATE.
- State GATE:
  - `clkout0_gate`=0.
  - `lock_s`=0 → failure.
  - After `GATE_SETTLE` cycles → RUN.
- State RUN:
  - `ddr_rst_n`=1, `pll_ready`=1, `retry_cnt` cleared to 0 on entry.
  - `lock_s`=0 → failure.
- Failure (taken from WAIT_LOCK, STABLE, GATE or RUN):
  - `retry_cnt` increments, saturating at 15.
  - New value == `MAX_RETRY` → FAIL; otherwise → RST.
- State FAIL:
  - Outputs as in RST, plus `pll_fail`=1.
  - Held until `restart` or `rst_n`.
- `restart` has the highest priority. In any state, the next state is RST, `retry_cnt`←0 and `pll_fail`←0.
- All outputs are registered and decoded from the state; there are no combinational paths from inputs to outputs.

## Timing
- Reset values (`rst_n`=0): state RST, timer 0, `pll_rst`=1, `clkout0_gate`=1, `ddr_rst_n`=0, `pll_ready`=0, `pll_fail`=0, `retry_cnt`=0, `lock_s`=0.
- `pll_rst` is high for exactly `RST_CYCLES` rising edges after `rst_n` deasserts, then falls.
- Lock-path latency:
  - `pll_lock` rise → `lock_s` high: 2 edges.
  - `lock_s` high → `clkout0_gate` low: `LOCK_STABLE` edges.
  - `clkout0_gate` low → `ddr_rst_n` and `pll_ready` high: `GATE_SETTLE` edges.
- Lock loss in RUN:
  - `pll_lock` falls → 2 edges to `lock_s`=0.
  - 1 further edge: `clkout0_gate`=1, `ddr_rst_n`=0, `pll_ready`=0 and `pll_rst`=1, all on the same edge.
- Lock glitches shorter than one `clk` period may be missed; this is acceptable. Any glitch captured in STABLE counts as a failure.
- `restart` and a failure condition in the same cycle: `restart` wins, so `retry_cnt` ends at 0.
- `rst_n` asserted mid-sequence: all outputs return to reset values immediately (asynchronously). The sequence restarts on deassertion.
- The timer never wraps: it saturates, and every terminal count is compared with ==.

## Test plan
- **Nominal lock** (`RST_CYCLES`=8, `LOCK_STABLE`=16, `GATE_SETTLE`=4). Release `rst_n` at edge 0 and raise `pll_lock` at edge 20. Required: `pll_rst` falls at edge 8, `clkout0_gate` falls at edge 38, `ddr_rst_n` and `pll_ready` rise at edge 42, `retry_cnt`=0.
- **Timeout retry** (`LOCK_TIMEOUT`=64, `MAX_RETRY`=3). Hold `pll_lock`=0. Required: `pll_rst` re-pulses for 8 cycles after each 64-cycle wait, `retry_cnt` goes 1 then 2, and on the 3rd timeout `pll_fail`=1 with `pll_rst` held high indefinitely.
- **Recovery from FAIL.** Pulse `restart` in FAIL, then supply lock. Required: `pll_fail`=0 and `retry_cnt`=0 on the next edge, and the nominal sequence follows.
- **Lock loss in RUN.** Drop `pll_lock` while `pll_ready`=1. Required: 3 edges later `clkout0_gate`=1, `ddr_rst_n`=0 and `pll_rst`=1, and `retry_cnt`=1. After relock, RUN is reached again and `retry_cnt` returns to 0.
- **Debounce.** In STABLE, drop `pll_lock` for 3 cycles at stable count 10. Required: return to RST with `retry_cnt`=1, and `clkout0_gate` never deasserts during this attempt.
- **Async reset mid-GATE.** Assert `rst_n`=0 while `clkout0_gate`=0. Required: `clkout0_gate`=1 and `pll_rst`=1 without waiting for a `clk` edge, and all other outputs at their reset values.
